// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32-style ALU with a valid/ready handshake.
// Logic and arithmetic operations finish one cycle after they are accepted.
// MUL, MULHU, DIVU and REMU run one iteration per cycle for WIDTH cycles:
// multiply uses shift-add and divide uses restoring division.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   op1/op2/alu_op are valid this cycle
//   in_ready   unit can accept an operation (high only in IDLE)
//   op1, op2   operands, WIDTH bits each
//   alu_op     4-bit operation code
//   out_valid  result/zero are valid (high only in DONE)
//   out_ready  consumer takes the result this cycle
//   result     registered result, WIDTH bits
//   zero       result == 0, taken from the result register
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {K_MUL, K_MULHU, K_DIVU, K_REMU} kind_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state, state_nxt;
  kind_t            kind;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] hi, lo, m;

  logic             accept, is_iter, last;
  kind_t            kind_in;
  logic [WIDTH-1:0] alu_res, iter_res;
  logic signed [WIDTH-1:0] s_op1, s_op2;
  logic [SHW-1:0]   shamt;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign zero      = (result == '0);
  assign accept    = in_valid && in_ready;
  assign last      = (state == S_BUSY) && (cnt == CNT_LAST);

  assign s_op1 = op1;
  assign s_op2 = op2;
  assign shamt = op2[SHW-1:0];

  // Decode the iterative opcodes.
  always_comb begin
    is_iter = 1'b1;
    kind_in = K_MUL;
    case (alu_op)
      4'b0011: kind_in = K_MUL;
      4'b0100: kind_in = K_MULHU;
      4'b0101: kind_in = K_DIVU;
      4'b1011: kind_in = K_REMU;
      default: is_iter = 1'b0;
    endcase
  end

  // Single-cycle operations; unused codes fall through to ADD.
  always_comb begin
    alu_res = op1 + op2;
    case (alu_op)
      4'b0000: alu_res = op1 & op2;
      4'b0001: alu_res = op1 | op2;
      4'b0110: alu_res = op1 - op2;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, (s_op1 < s_op2)};
      4'b1000: alu_res = op1 >> shamt;
      4'b1001: alu_res = op1 << shamt;
      4'b1010: alu_res = s_op1 >>> shamt;
      4'b1101: alu_res = op1 ^ op2;
      default: alu_res = op1 + op2;
    endcase
  end

  // One iteration step. Multiply: {hi,lo} holds partial product and the
  // remaining multiplier bits, m the multiplicand. Divide: hi is the partial
  // remainder, lo shifts out dividend bits and shifts in quotient bits, m is
  // the divisor. A zero divisor never borrows, so the quotient fills with
  // ones and the remainder ends up equal to the dividend.
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, m};
    div_ok   = ~div_diff[WIDTH];
    if (kind == K_DIVU || kind == K_REMU) begin
      hi_nxt = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], div_ok};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
    case (kind)
      K_MUL:   iter_res = lo_nxt;
      K_MULHU: iter_res = hi_nxt;
      K_DIVU:  iter_res = lo_nxt;
      default: iter_res = hi_nxt;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = is_iter ? S_BUSY : S_DONE;
      S_BUSY:  if (cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        if (!is_iter) result <= alu_res;
      end else if (state == S_BUSY) begin
        cnt <= cnt + SHW'(1);
        if (last) result <= iter_res;
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept && is_iter) begin
      kind <= kind_in;
      hi   <= '0;
      if (kind_in == K_MUL || kind_in == K_MULHU) begin
        lo <= op2;
        m  <= op1;
      end else begin
        lo <= op1;
        m  <= op2;
      end
    end else if (state == S_BUSY) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc (WIDTH = 32).
module tb_alu_mc;
  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  op1;
  logic [WIDTH-1:0]  op2;
  logic [3:0]        alu_op;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              zero;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] last_res;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  localparam logic [3:0]  S_OP [9] = '{4'b0110, 4'b0111, 4'b1010, 4'b1110, 4'b0000,
                                        4'b0001, 4'b1101, 4'b1001, 4'b1000};
  localparam logic [31:0] S_A  [9] = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'hF0F0_00FF,
                                        32'hF000_0000, 32'hFFFF_0000, 32'd1, 32'h8000_0000};
  localparam logic [31:0] S_B  [9] = '{32'd7, 32'd1, 32'h24, 32'd4, 32'h0FF0_0F0F,
                                        32'h0000_000F, 32'h0F0F_0F0F, 32'h3F, 32'h21};
  localparam logic [31:0] S_E  [9] = '{32'hFFFF_FFFE, 32'd1, 32'hF800_0000, 32'd7, 32'h00F0_000F,
                                        32'hF000_000F, 32'hF0F0_0F0F, 32'h8000_0000, 32'h4000_0000};

  localparam logic [3:0]  D_OP [4] = '{4'b0101, 4'b1011, 4'b0101, 4'b1011};
  localparam logic [31:0] D_A  [4] = '{32'd100, 32'd100, 32'd9, 32'd9};
  localparam logic [31:0] D_B  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
  localparam logic [31:0] D_E  [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; alu_op = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", zero); end
    last_res = '0;
  endtask

  task automatic test_single();
    for (int i = 0; i < 9; i++) begin
      start_op(S_OP[i], S_A[i], S_B[i]);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got=%b want=1", i, out_valid); end
      total++; if (result !== S_E[i]) begin bad++; $display("FAIL single_result[%0d] got=%h want=%h", i, result, S_E[i]); end
      total++; if (zero !== 1'b0) begin bad++; $display("FAIL single_zero[%0d] got=%b want=0", i, zero); end
      last_res = S_E[i];
      release_result();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_back_idle[%0d] got=%b want=1", i, in_ready); end
    end
  endtask

  task automatic test_mul();
    logic [3:0]  ops [2];
    logic [31:0] exps [2];
    int cyc;
    logic ready_ok, held;
    ops[0] = 4'b0011; exps[0] = 32'd0;
    ops[1] = 4'b0100; exps[1] = 32'd1;
    for (int i = 0; i < 2; i++) begin
      start_op(ops[i], 32'h0001_0000, 32'h0001_0000);
      cyc = 0; ready_ok = 1'b1; held = 1'b1;
      while (out_valid !== 1'b1 && cyc < 40) begin
        if (in_ready !== 1'b0) ready_ok = 1'b0;
        if (result !== last_res) held = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
      total++; if (cyc != 32) begin bad++; $display("FAIL mul_latency[%0d] got=%0d want=32", i, cyc); end
      total++; if (!ready_ok) begin bad++; $display("FAIL mul_in_ready_busy[%0d] got=1 want=0", i); end
      total++; if (!held) begin bad++; $display("FAIL mul_result_held[%0d] got=changed want=%h", i, last_res); end
      total++; if (result !== exps[i]) begin bad++; $display("FAIL mul_result[%0d] got=%h want=%h", i, result, exps[i]); end
      total++; if (zero !== (exps[i] == 32'd0)) begin bad++; $display("FAIL mul_zero[%0d] got=%b want=%b", i, zero, exps[i] == 32'd0); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mul_in_ready_done[%0d] got=%b want=0", i, in_ready); end
      last_res = exps[i];
      release_result();
    end
  endtask

  task automatic test_div();
    int cyc;
    for (int i = 0; i < 4; i++) begin
      start_op(D_OP[i], D_A[i], D_B[i]);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
        op1 = $urandom; op2 = $urandom; alu_op = 4'($urandom);
        in_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b0;
      total++; if (cyc != 32) begin bad++; $display("FAIL div_latency[%0d] got=%0d want=32", i, cyc); end
      total++; if (result !== D_E[i]) begin bad++; $display("FAIL div_result[%0d] got=%h want=%h", i, result, D_E[i]); end
      last_res = D_E[i];
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic stable;
    start_op(4'b0010, 32'd10, 32'd20);
    total++; if (result !== 32'd30) begin bad++; $display("FAIL bp_first got=%h want=1e", result); end
    alu_op = 4'b0110; op1 = 32'd1; op2 = 32'd2; in_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (result !== 32'd30 || zero !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    total++; if (!stable) begin bad++; $display("FAIL bp_stable got=r%h z%b v%b rdy%b want=r1e z0 v1 rdy0", result, zero, out_valid, in_ready); end
    alu_op = 4'b1101; op1 = 32'hFF; op2 = 32'h0F;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_idle_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'd30) begin bad++; $display("FAIL bp_no_same_edge_accept got=%h want=1e", result); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b want=1", out_valid); end
    total++; if (result !== 32'hF0) begin bad++; $display("FAIL bp_next_result got=%h want=f0", result); end
    release_result();
  endtask

  task automatic test_reset_busy();
    logic quiet;
    start_op(4'b0101, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstbusy_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstbusy_out_valid got=%b want=0", out_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rstbusy_result got=%h want=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL rstbusy_zero got=%b want=1", zero); end
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || result !== 32'd0) quiet = 1'b0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL rstbusy_no_result got=v%b r%h want=v0 r0", out_valid, result); end
    start_op(4'b0010, 32'd2, 32'd2);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstbusy_add_valid got=%b want=1", out_valid); end
    total++; if (result !== 32'd4) begin bad++; $display("FAIL rstbusy_add_result got=%h want=4", result); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32 ALU.
- Executes all existing ALU operations in one cycle. Adds iterative unsigned multiply (low/high) and unsigned divide/remainder on a shift-add / restoring-division datapath.
- Sits between the decode/operand stage and writeback of the multi-cycle processor.
- Uses a valid/ready handshake on input and output so the control FSM can stall on long operations.

Parameters:
- WIDTH, 32, operand and result width in bits (power of 2, 8..64).
- SHW, $clog2(WIDTH), number of operand-2 bits used as the shift amount (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  op1/op2/alu_op are valid this cycle.
- in_ready  output  1  unit can accept an operation; high only in IDLE.
- op1  input  WIDTH  operand 1.
- op2  input  WIDTH  operand 2.
- alu_op  input  4  operation code.
- out_valid  output  1  result and zero are valid; high only in DONE.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- zero  output  1  (result == 0), combinational from the result register.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE, result = 0, out_valid = 0, in_ready = 1, zero = 1, iteration counter = 0.
- Reset mid-operation aborts the operation; no result is produced.
- Accept: on an edge where in_valid && in_ready, op1, op2 and alu_op are captured. Inputs are ignored at all other times, including any changes during BUSY or DONE.

Single-cycle op codes (result registered at the accept edge, next state DONE, latency 1):
- AND 0000: op1 & op2.
- OR 0001: op1 | op2.
- ADD 0010: op1 + op2, modulo 2^WIDTH.
- SUB 0110: op1 - op2, modulo 2^WIDTH.
- LESS_THAN 0111: signed op1 < signed op2, zero-extended to WIDTH.
- SHIFT_RIGHT 1000: op1 >> op2[SHW-1:0].
- SHIFT_LEFT 1001: op1 << op2[SHW-1:0].
- SHIFT_RIGHT_ARITH 1010: arithmetic right shift of op1 by op2[SHW-1:0].
- XOR 1101: op1 ^ op2.
- Unused codes 1100, 1110, 1111: behave as ADD.

Iterative op codes (next state BUSY, counter = 0):
- MUL 0011: low WIDTH bits of op1*op2.
- MULHU 0100: high WIDTH bits of unsigned op1*op2.
- DIVU 0101: unsigned op1/op2.
- REMU 1011: unsigned op1%op2.

BUSY:
- One shift-add or restore-subtract iteration per cycle; counter increments each cycle.
- On the edge where the counter reaches WIDTH-1, the final result is written and state moves to DONE.
- Timing: accept edge = E0. out_valid first seen high after edge E0+WIDTH (32 cycles for WIDTH=32). Single-cycle ops: after E0.
- Divide by zero: no early exit; the full WIDTH cycles still run. DIVU returns all ones; REMU returns op1 (RISC-V semantics).

DONE:
- out_valid = 1; result is held stable.
- On an edge with out_ready = 1: state goes to IDLE and out_valid drops.
- No accept occurs in the same edge; the next operation is accepted no earlier than the following edge (max throughput 1 op per 2 cycles).

General:
- result changes only when an operation completes; it is never driven by partial iterations.
- zero always tracks the result register.

Test Plan:
- Reset, then 4 idle cycles -> in_ready=1, out_valid=0, result=0, zero=1.
- Single-cycle sweep (WIDTH=32): SUB 5-7 -> 0xFFFFFFFE after 1 cycle; LESS_THAN 0xFFFFFFFF vs 1 -> 1; SHIFT_RIGHT_ARITH 0x80000000 by 0x24 -> 0xF8000000 (only 5 bits used); code 1110 with 3,4 -> 7.
- MUL 0x0001_0000 x 0x0001_0000 -> result 0 with zero=1; MULHU same operands -> 0x00000001. Each: out_valid rises exactly 32 cycles after accept, in_ready=0 throughout.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9. Operand inputs toggled randomly during BUSY do not change results.
- Output backpressure: hold out_ready=0 for 10 cycles after completion -> result, zero and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next cycle, and the next op is accepted one cycle later.
- Assert rst during BUSY at iteration 15 of a DIVU -> next cycle IDLE, out_valid=0, result=0. A following ADD 2+2 -> 4.
